// File: rtl/ser160_par2ser_pkg.sv
// ser160_par2ser_pkg: field positions, FSM encoding and word helpers for the nibble-link transmitter
package ser160_par2ser_pkg;
    localparam int WORD_W      = 16;
    localparam int CTRL_ENA    = 3;
    localparam int CTRL_DLY_HI = 2;
    localparam int CTRL_DLY_LO = 0;
    localparam int W_START     = 15;
    localparam int W_END       = 14;
    localparam int NIB_HI      = 11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GAP  = 3'd1,
        S_DLY  = 3'd2,
        S_N2   = 3'd3,
        S_N1   = 3'd4,
        S_N0   = 3'd5,
        S_WAIT = 3'd6
    } state_t;

    // Word being shifted out: only its end mark and three nibbles matter once a packet has started
    typedef struct packed {
        logic        last;
        logic [11:0] nibs;
    } cur_t;

    function automatic cur_t to_cur(input logic [WORD_W-1:0] w);
        return '{last: w[W_END], nibs: w[NIB_HI:0]};
    endfunction
endpackage

// File: rtl/ser160_par2ser_buf.sv
// ser160_par2ser_buf: one-entry valid/ready holding register with consume and flush
module ser160_par2ser_buf
    import ser160_par2ser_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              allow,
    input  logic              flush,
    input  logic              consume,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [WORD_W-1:0] data,
    output logic              full
);
    assign wr_ready = allow && !reset && (!full || consume);

    // Occupancy: a write on the consuming edge refills the entry so back-to-back words never bubble
    always_ff @(posedge clk) begin
        if (reset || flush) full <= 1'b0;
        else if (wr_valid && wr_ready) full <= 1'b1;
        else if (consume) full <= 1'b0;
    end

    // Payload needs no reset; it is only looked at while full is set
    always_ff @(posedge clk) begin
        if (wr_valid && wr_ready) data <= wr_data;
    end
endmodule

// File: rtl/ser160_par2ser.sv
// ser160_par2ser: serialises 16-bit event words MSB-nibble first with tin/tout strobes on the 160 MHz nibble link
module ser160_par2ser
    import ser160_par2ser_pkg::*;
#(
    parameter logic [3:0] IDLE_NIB = 4'h0,
    parameter int         MIN_GAP  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sync,
    input  logic [3:0]        ctrl,
    input  logic              run,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    output logic [3:0]        dout,
    output logic              tin,
    output logic              tout,
    output logic              busy,
    output logic              underrun,
    output logic              framing
);
    logic              go, flush, consume, full, set_underrun, set_framing, tin_n, tout_n;
    logic [WORD_W-1:0] buf_data;
    logic [1:0]        unused_rsvd;
    logic [2:0]        cnt, cnt_n;
    logic [3:0]        dout_n;
    state_t            state, state_n;
    cur_t              cur, cur_n;

    assign go          = ctrl[CTRL_ENA] && run;
    assign flush       = sync && !go;
    assign cur_n       = consume ? to_cur(buf_data) : cur;
    assign busy        = state != S_IDLE;
    assign unused_rsvd = buf_data[13:12];

    ser160_par2ser_buf u_buf (
        .clk      (clk),
        .reset    (reset),
        .allow    (go),
        .flush    (flush),
        .consume  (consume),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .data     (buf_data),
        .full     (full)
    );

    // State, counters, current word and registered link outputs; outputs move only on sync edges
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= 3'd0;
            cur      <= '0;
            dout     <= IDLE_NIB;
            tin      <= 1'b0;
            tout     <= 1'b0;
            underrun <= 1'b0;
            framing  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            cur      <= cur_n;
            underrun <= ctrl[CTRL_ENA] && (underrun || set_underrun);
            framing  <= ctrl[CTRL_ENA] && (framing || set_framing);
            if (sync) begin
                dout <= dout_n;
                tin  <= tin_n;
                tout <= tout_n;
            end
        end
    end

    // Next state: the tin period is the first DLY period, so N2 lands delay+1 syncs after tin
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        consume      = 1'b0;
        set_underrun = 1'b0;
        set_framing  = 1'b0;
        if (flush) state_n = S_IDLE;
        else if (sync) begin
            case (state)
                S_IDLE: begin
                    consume     = full;
                    set_framing = full && !buf_data[W_START];
                    if (full && buf_data[W_START]) begin
                        state_n = S_DLY;
                        cnt_n   = ctrl[CTRL_DLY_HI:CTRL_DLY_LO];
                    end
                end
                S_DLY: begin
                    state_n = (cnt == 3'd0) ? S_N2 : S_DLY;
                    cnt_n   = cnt - 3'd1;
                end
                S_N2: state_n = S_N1;
                S_N1: state_n = S_N0;
                S_N0: begin
                    if (cur.last) begin
                        state_n = S_GAP;
                        cnt_n   = 3'(MIN_GAP);
                    end else begin
                        consume      = full;
                        state_n      = full ? S_N2 : S_WAIT;
                        set_underrun = !full;
                    end
                end
                S_WAIT: begin
                    consume = full;
                    state_n = full ? S_N2 : S_WAIT;
                end
                S_GAP: begin
                    state_n = (cnt <= 3'd1) ? S_IDLE : S_GAP;
                    cnt_n   = cnt - 3'd1;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Output values for the period that begins at the next sync edge
    always_comb begin
        dout_n = state_n == S_N2 ? cur_n.nibs[11:8] :
                 state_n == S_N1 ? cur_n.nibs[7:4]  :
                 state_n == S_N0 ? cur_n.nibs[3:0]  : IDLE_NIB;
        tin_n  = state == S_IDLE && state_n == S_DLY;
        tout_n = state_n == S_N0 && cur_n.last;
    end
endmodule
